// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - SPI master front-end for the 8-channel 12-bit A2D converter
// Optional feature macro: A2D_RES_INVERT_EN publishes the one's complement of the result.
module a2d_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_conv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] A2D_res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [2:0] {IDLE, FRAME1, GAP, FRAME2, DONE} state_t;

  localparam logic [4:0] DIV_ENTRY    = 5'b10000;
  localparam logic [4:0] DIV_PRE_RISE = 5'b01111;
  localparam logic [4:0] DIV_PRE_FALL = 5'b11111;
  localparam logic [4:0] BITS_DONE    = 5'd16;
  localparam logic [4:0] BITS_PUBLISH = 5'd17;

  state_t      state_q, state_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  chnl_q, chnl_d;
  logic        miso_smpl_q, miso_smpl_d;
  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cmplt_q, cmplt_d;
  logic [11:0] res_q, res_d;
  logic [11:0] res_new;
  logic        in_frame;

`ifdef A2D_RES_INVERT_EN
  assign res_new = ~shift_q[11:0];
`else
  assign res_new = shift_q[11:0];
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    chnl_d      = chnl_q;
    miso_smpl_d = miso_smpl_q;
    cmplt_d     = cmplt_q;
    res_d       = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_conv) begin
          chnl_d    = chnnl;
          shift_d   = {2'b00, chnnl, 11'h000};
          cmplt_d   = 1'b0;
          div_d     = DIV_ENTRY;
          bit_cnt_d = 5'd0;
          state_d   = FRAME1;
        end
      end
      FRAME1, FRAME2: begin
        // Count 17 marks the extra cycle after frame 2 where the result is published.
        if (bit_cnt_q == BITS_PUBLISH) begin
          res_d   = res_new;
          cmplt_d = 1'b1;
          state_d = DONE;
        end else begin
          div_d = div_q + 5'd1;
          if (div_q == DIV_PRE_RISE) begin
            miso_smpl_d = MISO;
            bit_cnt_d   = bit_cnt_q + 5'd1;
          end
          if (div_q == DIV_PRE_FALL && bit_cnt_q != 5'd0) begin
            shift_d = {shift_q[14:0], miso_smpl_q};
          end
          if (div_q == DIV_PRE_FALL && bit_cnt_q == BITS_DONE) begin
            if (state_q == FRAME1) begin
              state_d = GAP;
              div_d   = 5'd0;
            end else begin
              bit_cnt_d = BITS_PUBLISH;
            end
          end
        end
      end
      GAP: begin
        div_d = div_q + 5'd1;
        if (div_q == DIV_PRE_FALL) begin
          shift_d   = {2'b00, chnl_q, 11'h000};
          div_d     = DIV_ENTRY;
          bit_cnt_d = 5'd0;
          state_d   = FRAME2;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from next-state values so they align with the state change.
    in_frame = (state_d == FRAME1 || state_d == FRAME2) && (bit_cnt_d != BITS_PUBLISH);
    ss_n_d   = ~in_frame;
    sclk_d   = in_frame ? div_d[4] : 1'b1;
    mosi_d   = in_frame ? shift_d[15] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= 5'd0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 16'h0000;
      chnl_q      <= 3'd0;
      miso_smpl_q <= 1'b0;
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmplt_q     <= 1'b0;
      res_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      chnl_q      <= chnl_d;
      miso_smpl_q <= miso_smpl_d;
      ss_n_q      <= ss_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cmplt_q     <= cmplt_d;
      res_q       <= res_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign cnv_cmplt = cmplt_q;
  assign A2D_res   = res_q;

endmodule
